// File: rtl/aes_out_align.sv
// aes_out_align: holds side data issued by the AES control stage until the
// matching core result arrives. It then combines the two according to MODE,
// buffers the beat for a back-pressured output stream, and returns the
// CBC-encryption chaining IV to the control stage. The core cannot stall, so
// a credit count throttles the control stage instead.
module aes_out_align #(
  parameter int N_PIPES   = 4,
  parameter int MODE      = 0,   // 0 ECB, 1 CTR, 2 CBC
  parameter int OPERATION = 0,   // 0 encrypt, 1 decrypt
  parameter int DEPTH     = 16   // power of two, >= 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ctrl_valid,
  input  logic [N_PIPES*128-1:0] ctrl_data,
  input  logic [N_PIPES*16-1:0]  ctrl_keep,
  input  logic                   ctrl_last,
  output logic                   ctrl_ready,
  input  logic                   core_valid,
  input  logic [N_PIPES*128-1:0] core_data,
  output logic                   ovalid,
  output logic [N_PIPES*128-1:0] odata,
  output logic [N_PIPES*16-1:0]  okeep,
  output logic                   olast,
  input  logic                   iready,
  output logic [127:0]           ofeedbackiv,
  output logic                   ofeedbackvalid,
  output logic                   odone,
  output logic                   oerror
);

  localparam int DW = N_PIPES * 128;
  localparam int KW = N_PIPES * 16;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic CTR_MODE = (MODE == 1);
  localparam logic CBC_ENC  = (MODE == 2) && (OPERATION == 0);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Side FIFO storage and pointers (extra pointer bit separates full from empty)
  logic [DW-1:0] side_data_mem [DEPTH];
  logic [KW-1:0] side_keep_mem [DEPTH];
  logic          side_last_mem [DEPTH];
  logic [CW-1:0] side_wr_q, side_wr_d, side_rd_q, side_rd_d;
  logic [CW-1:0] side_cnt;
  logic          side_full, side_empty, side_push, side_pop;

  // Combine stage
  logic          comb_valid_q, comb_valid_d;
  logic [DW-1:0] comb_data_q, comb_data_d;
  logic [KW-1:0] comb_keep_q, comb_keep_d;
  logic          comb_last_q, comb_last_d;

  // Output FIFO: registered head plus a backing memory
  logic [DW-1:0] out_data_mem [DEPTH];
  logic [KW-1:0] out_keep_mem [DEPTH];
  logic          out_last_mem [DEPTH];
  logic [CW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic          out_mem_nonempty, out_load, load_from_mem, load_from_comb;
  logic          out_mem_push, pop_out;
  logic          ovalid_q, ovalid_d;
  logic [DW-1:0] odata_q, odata_d;
  logic [KW-1:0] okeep_q, okeep_d;
  logic          olast_q, olast_d;

  // Credits, feedback, status
  logic [CW-1:0] credit_q, credit_d;
  logic          ctrl_ready_q, ctrl_ready_d;
  logic          fb_valid_q, fb_valid_d;
  logic [127:0]  fb_iv_q, fb_iv_d;
  logic          odone_q, odone_d;
  logic          oerror_q, oerror_d;

  assign side_cnt   = side_wr_q - side_rd_q;
  assign side_full  = (side_cnt == FULL_CNT);
  assign side_empty = (side_cnt == '0);
  assign side_push  = ctrl_valid & ~side_full;
  assign side_pop   = core_valid & ~side_empty;

  assign pop_out          = ovalid_q & iready;
  assign out_mem_nonempty = (out_wr_q != out_rd_q);
  assign out_load         = ~ovalid_q | iready;
  assign load_from_mem    = out_load & out_mem_nonempty;
  assign load_from_comb   = out_load & ~out_mem_nonempty & comb_valid_q;
  assign out_mem_push     = comb_valid_q & ~load_from_comb;

  // Next-state logic for pointers, combine stage, output head, credits and status
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    side_wr_d    = side_wr_q;
    side_rd_d    = side_rd_q;
    comb_valid_d = side_pop;
    comb_data_d  = comb_data_q;
    comb_keep_d  = comb_keep_q;
    comb_last_d  = comb_last_q;
    out_wr_d     = out_wr_q;
    out_rd_d     = out_rd_q;
    ovalid_d     = ovalid_q;
    odata_d      = odata_q;
    okeep_d      = okeep_q;
    olast_d      = olast_q;
    credit_d     = credit_q;
    fb_valid_d   = CBC_ENC & core_valid;
    fb_iv_d      = fb_iv_q;
    odone_d      = pop_out & olast_q;
    oerror_d     = oerror_q | (ctrl_valid & side_full) | (core_valid & side_empty);

    if (side_push) side_wr_d = side_wr_q + ONE;

    if (side_pop) begin
      side_rd_d   = side_rd_q + ONE;
      comb_data_d = CTR_MODE ? (core_data ^ side_data_mem[side_rd_q[AW-1:0]]) : core_data;
      comb_keep_d = side_keep_mem[side_rd_q[AW-1:0]];
      comb_last_d = side_last_mem[side_rd_q[AW-1:0]];
    end

    // Head register refills from the memory first so beats stay in order
    if (out_load) ovalid_d = out_mem_nonempty | comb_valid_q;
    if (load_from_mem) begin
      odata_d  = out_data_mem[out_rd_q[AW-1:0]];
      okeep_d  = out_keep_mem[out_rd_q[AW-1:0]];
      olast_d  = out_last_mem[out_rd_q[AW-1:0]];
      out_rd_d = out_rd_q + ONE;
    end else if (load_from_comb) begin
      odata_d = comb_data_q;
      okeep_d = comb_keep_q;
      olast_d = comb_last_q;
    end
    if (out_mem_push) out_wr_d = out_wr_q + ONE;

    // Credits track beats inside the block; saturate at both ends
    if (side_push && !pop_out && credit_q != FULL_CNT) credit_d = credit_q + ONE;
    else if (pop_out && !side_push && credit_q != '0)  credit_d = credit_q - ONE;
    ctrl_ready_d = (credit_d < FULL_CNT);

    if (CBC_ENC && core_valid) fb_iv_d = core_data[DW-1 -: 128];
  end

  // FIFO storage writes; contents are qualified by the pointers
  // NOTE: the storage arrays carry no reset; pointers alone decide validity, so reset logic on them would be wasted.
  always_ff @(posedge clk) begin
    if (side_push) begin
      side_data_mem[side_wr_q[AW-1:0]] <= ctrl_data;
      side_keep_mem[side_wr_q[AW-1:0]] <= ctrl_keep;
      side_last_mem[side_wr_q[AW-1:0]] <= ctrl_last;
    end
    if (out_mem_push) begin
      out_data_mem[out_wr_q[AW-1:0]] <= comb_data_q;
      out_keep_mem[out_wr_q[AW-1:0]] <= comb_keep_q;
      out_last_mem[out_wr_q[AW-1:0]] <= comb_last_q;
    end
  end

  // Control and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!resetn) begin
      side_wr_q    <= '0;
      side_rd_q    <= '0;
      comb_valid_q <= 1'b0;
      comb_data_q  <= '0;
      comb_keep_q  <= '0;
      comb_last_q  <= 1'b0;
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      ovalid_q     <= 1'b0;
      odata_q      <= '0;
      okeep_q      <= '0;
      olast_q      <= 1'b0;
      credit_q     <= '0;
      ctrl_ready_q <= 1'b1;
      fb_valid_q   <= 1'b0;
      fb_iv_q      <= '0;
      odone_q      <= 1'b0;
      oerror_q     <= 1'b0;
    end else begin
      side_wr_q    <= side_wr_d;
      side_rd_q    <= side_rd_d;
      comb_valid_q <= comb_valid_d;
      comb_data_q  <= comb_data_d;
      comb_keep_q  <= comb_keep_d;
      comb_last_q  <= comb_last_d;
      out_wr_q     <= out_wr_d;
      out_rd_q     <= out_rd_d;
      ovalid_q     <= ovalid_d;
      odata_q      <= odata_d;
      okeep_q      <= okeep_d;
      olast_q      <= olast_d;
      credit_q     <= credit_d;
      ctrl_ready_q <= ctrl_ready_d;
      fb_valid_q   <= fb_valid_d;
      fb_iv_q      <= fb_iv_d;
      odone_q      <= odone_d;
      oerror_q     <= oerror_d;
    end
  end

  assign ctrl_ready     = ctrl_ready_q;
  assign ovalid         = ovalid_q;
  assign odata          = odata_q;
  assign okeep          = okeep_q;
  assign olast          = olast_q;
  assign ofeedbackiv    = fb_iv_q;
  assign ofeedbackvalid = fb_valid_q;
  assign odone          = odone_q;
  assign oerror         = oerror_q;

endmodule

// File: tb/tb_aes_out_align.sv
// Bench for aes_out_align: three instances (ECB, CTR, CBC-encrypt) share the
// same stimulus. Expected beats go into per-instance queues when a core result
// is issued; a negedge monitor pops and compares on every output handshake.
module tb_aes_out_align;

  localparam int DW = 512;
  localparam int KW = 64;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ctrl_valid = 1'b0;
  logic [DW-1:0] ctrl_data = '0;
  logic [KW-1:0] ctrl_keep = '0;
  logic          ctrl_last = 1'b0;
  logic          core_valid = 1'b0;
  logic [DW-1:0] core_data = '0;
  logic          iready = 1'b0;

  logic [2:0]    ctrl_ready_v, ovalid_v, olast_v, fbvalid_v, odone_v, oerror_v;
  logic [DW-1:0] odata_v [3];
  logic [KW-1:0] okeep_v [3];
  logic [127:0]  fbiv_v  [3];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic mon_en = 1'b0;

  beat_t side_q[$];
  beat_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  aes_out_align #(.N_PIPES(4), .MODE(0), .OPERATION(0), .DEPTH(16)) u_ecb (
    .clk(clk), .resetn(resetn), .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data),
    .ctrl_keep(ctrl_keep), .ctrl_last(ctrl_last), .ctrl_ready(ctrl_ready_v[0]),
    .core_valid(core_valid), .core_data(core_data), .ovalid(ovalid_v[0]),
    .odata(odata_v[0]), .okeep(okeep_v[0]), .olast(olast_v[0]), .iready(iready),
    .ofeedbackiv(fbiv_v[0]), .ofeedbackvalid(fbvalid_v[0]), .odone(odone_v[0]),
    .oerror(oerror_v[0]));

  aes_out_align #(.N_PIPES(4), .MODE(1), .OPERATION(0), .DEPTH(16)) u_ctr (
    .clk(clk), .resetn(resetn), .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data),
    .ctrl_keep(ctrl_keep), .ctrl_last(ctrl_last), .ctrl_ready(ctrl_ready_v[1]),
    .core_valid(core_valid), .core_data(core_data), .ovalid(ovalid_v[1]),
    .odata(odata_v[1]), .okeep(okeep_v[1]), .olast(olast_v[1]), .iready(iready),
    .ofeedbackiv(fbiv_v[1]), .ofeedbackvalid(fbvalid_v[1]), .odone(odone_v[1]),
    .oerror(oerror_v[1]));

  aes_out_align #(.N_PIPES(4), .MODE(2), .OPERATION(0), .DEPTH(16)) u_cbc (
    .clk(clk), .resetn(resetn), .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data),
    .ctrl_keep(ctrl_keep), .ctrl_last(ctrl_last), .ctrl_ready(ctrl_ready_v[2]),
    .core_valid(core_valid), .core_data(core_data), .ovalid(ovalid_v[2]),
    .odata(odata_v[2]), .okeep(okeep_v[2]), .olast(olast_v[2]), .iready(iready),
    .ofeedbackiv(fbiv_v[2]), .ofeedbackvalid(fbvalid_v[2]), .odone(odone_v[2]),
    .oerror(oerror_v[2]));

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one control beat for a single cycle and remember its side data
  task automatic ctrl_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t s;
    s = '{d: d, k: k, l: l};
    side_q.push_back(s);
    ctrl_valid = 1'b1;
    ctrl_data  = d;
    ctrl_keep  = k;
    ctrl_last  = l;
    tick();
    ctrl_valid = 1'b0;
  endtask

  // Present a core result (held until the caller advances) and queue the expected beats
  task automatic core_set(input logic [DW-1:0] d);
    beat_t s;
    if (side_q.size() != 0) begin
      s = side_q.pop_front();
      q0.push_back('{d: d,         k: s.k, l: s.l});
      q1.push_back('{d: d ^ s.d,   k: s.k, l: s.l});
      q2.push_back('{d: d,         k: s.k, l: s.l});
    end
    core_valid = 1'b1;
    core_data  = d;
  endtask

  task automatic core_beat(input logic [DW-1:0] d);
    core_set(d);
    tick();
    core_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", DW'(q0.size() + q1.size() + q2.size()), '0);
    repeat (2) tick();
  endtask

  // Monitor: output beats, odone after olast handshake, CBC feedback pulse
  logic [2:0]    prev_hs = '0;
  logic [2:0]    prev_last = '0;
  logic          prev_cv = 1'b0;
  logic [DW-1:0] prev_cd = '0;

  always @(negedge clk) begin
    beat_t e;
    logic  got;
    if (!mon_en) begin
      prev_hs   = '0;
      prev_last = '0;
      prev_cv   = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (prev_hs[i]) check($sformatf("odone_%0d", i), DW'(odone_v[i]), DW'(prev_last[i]));
        if (ovalid_v[i] && iready) begin
          got = 1'b0;
          e   = '0;
          case (i)
            0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); got = 1'b1; end
          endcase
          if (!got) begin
            chk_cnt++;
            $display("FAIL unexpected_beat_%0d: odata=%0h with no beat expected", i, odata_v[i]);
          end else begin
            check($sformatf("odata_%0d", i), odata_v[i], e.d);
            check($sformatf("okeep_%0d", i), DW'(okeep_v[i]), DW'(e.k));
            check($sformatf("olast_%0d", i), DW'(olast_v[i]), DW'(e.l));
          end
        end
        prev_hs[i]   = ovalid_v[i] & iready;
        prev_last[i] = olast_v[i];
      end
      check("fbvalid_cbc", DW'(fbvalid_v[2]), DW'(prev_cv));
      check("fbvalid_ecb", DW'(fbvalid_v[0]), '0);
      check("fbvalid_ctr", DW'(fbvalid_v[1]), '0);
      if (prev_cv) check("fbiv_cbc", DW'(fbiv_v[2]), DW'(prev_cd[DW-1 -: 128]));
      prev_cv = core_valid;
      prev_cd = core_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ctrl_ready_%0d", i), DW'(ctrl_ready_v[i]), DW'(1));
      check($sformatf("rst_ovalid_%0d", i),     DW'(ovalid_v[i]), '0);
      check($sformatf("rst_oerror_%0d", i),     DW'(oerror_v[i]), '0);
      check($sformatf("rst_odata_%0d", i),      odata_v[i], '0);
      check($sformatf("rst_fbvalid_%0d", i),    DW'(fbvalid_v[i]), '0);
    end
    resetn = 1'b1;
    tick();
    mon_en = 1'b1;

    // ECB-style flow: three beats, core results 10 cycles later, 2-cycle latency
    iready = 1'b1;
    ctrl_beat({4{128'h000102030405060708090A0B0C0D0E0F}}, {64{1'b1}}, 1'b0);
    ctrl_beat({4{128'h101112131415161718191A1B1C1D1E1F}}, {64{1'b1}}, 1'b0);
    ctrl_beat({4{128'h202122232425262728292A2B2C2D2E2F}}, {64{1'b1}}, 1'b1);
    repeat (10) tick();
    core_set({4{128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA}});
    tick();
    core_set({4{128'hBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBB}});
    @(negedge clk);
    check("ecb_lat_cycle1", DW'(ovalid_v[0]), '0);
    tick();
    core_set({4{128'hCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCC}});
    @(negedge clk);
    check("ecb_lat_cycle2", DW'(ovalid_v[0]), DW'(1));
    check("ecb_first_data", odata_v[0], {4{128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA}});
    tick();
    core_valid = 1'b0;
    wait_drain();

    // CTR keystream XOR gives all ones
    ctrl_beat({4{128'h00112233445566778899AABBCCDDEEFF}}, {64{1'b1}}, 1'b1);
    repeat (2) tick();
    core_beat({4{128'hFFEEDDCCBBAA99887766554433221100}});
    wait_drain();

    // CBC-encrypt feedback from the top lane, with a partial keep
    ctrl_beat({4{128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A}}, 64'h0000_FFFF_FFFF_FFFF, 1'b1);
    tick();
    core_beat({128'h0123456789ABCDEF0123456789ABCDEF, {3{128'h0F0E0D0C0B0A09080706050403020100}}});
    wait_drain();

    // Back-pressure: fill all credits with the sink stalled
    iready = 1'b0;
    for (int i = 0; i < 15; i++) ctrl_beat({4{128'(i + 1)}}, {64{1'b1}}, 1'b0);
    @(negedge clk);
    check("ready_after_15", DW'(ctrl_ready_v[0]), DW'(1));
    ctrl_beat({4{128'd16}}, {64{1'b1}}, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("ready_after_16_%0d", i), DW'(ctrl_ready_v[i]), '0);
    for (int i = 0; i < 16; i++) core_beat({4{128'(3 * i + 7)}});
    repeat (3) tick();
    @(negedge clk);
    check("stall_ovalid", DW'(ovalid_v[1]), DW'(1));
    repeat (4) tick();
    @(negedge clk);
    check("stall_hold_data_ecb", odata_v[0], q0[0].d);
    check("stall_hold_data_ctr", odata_v[1], q1[0].d);
    check("stall_hold_last",     DW'(olast_v[0]), '0);
    iready = 1'b1;
    tick();
    iready = 1'b0;
    @(negedge clk);
    check("ready_after_handshake", DW'(ctrl_ready_v[0]), DW'(1));
    tick();
    iready = 1'b1;
    wait_drain();

    // Core result with nothing in the side FIFO
    core_valid = 1'b1;
    core_data  = {4{128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF}};
    tick();
    core_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("err_oerror_%0d", i), DW'(oerror_v[i]), DW'(1));
    repeat (2) tick();
    @(negedge clk);
    check("err_no_ovalid", DW'(ovalid_v[0]), '0);

    // Asynchronous reset with beats still buffered
    iready = 1'b0;
    ctrl_beat({4{128'h11}}, {64{1'b1}}, 1'b0);
    ctrl_beat({4{128'h22}}, {64{1'b1}}, 1'b1);
    core_beat({4{128'h33}});
    core_beat({4{128'h44}});
    repeat (3) tick();
    @(negedge clk);
    check("pre_reset_ovalid", DW'(ovalid_v[0]), DW'(1));
    mon_en = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arst_ovalid_%0d", i),     DW'(ovalid_v[i]), '0);
      check($sformatf("arst_oerror_%0d", i),     DW'(oerror_v[i]), '0);
      check($sformatf("arst_ctrl_ready_%0d", i), DW'(ctrl_ready_v[i]), DW'(1));
      check($sformatf("arst_olast_%0d", i),      DW'(olast_v[i]), '0);
      check($sformatf("arst_odata_%0d", i),      odata_v[i], '0);
    end
    q0.delete();
    q1.delete();
    q2.delete();
    side_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    iready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("no_beat_after_reset", DW'(ovalid_v[0]), '0);
    tick();
    mon_en = 1'b1;

    // Fresh traffic after reset flows normally
    ctrl_beat({4{128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F}}, 64'h00FF_00FF_00FF_00FF, 1'b1);
    core_beat({4{128'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0}});
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/aes_out_align.md
Name: aes_out_align

Overview:
- Sits directly downstream of the AES control stage and the AES pipeline core.
- Holds the plaintext/ciphertext side data (data, keep, last) that the control stage issues, until the matching core result arrives.
- Combines side data with the core result per mode, buffers results for a back-pressured output stream, and returns the CBC-encryption chaining IV to the control stage.
- Throttles the control stage with a credit count, because the core has no back-pressure.

Parameters:
N_PIPES, 4, number of 128-bit lanes per beat
MODE, 0, 0-ECB, 1-CTR, 2-CBC (must match control stage)
OPERATION, 0, 0-encryption, 1-decryption
DEPTH, 16, side-FIFO and output-FIFO depth in beats (power of 2, ≥4)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ctrl_valid  in  1  control stage issued a beat this cycle
ctrl_data  in  N_PIPES*128  side data of the issued beat
ctrl_keep  in  N_PIPES*16  byte keep of the issued beat
ctrl_last  in  1  last beat of the message
ctrl_ready  out  1  credit available; drives the control stage's iready
core_valid  in  1  core result valid (no back-pressure)
core_data  in  N_PIPES*128  core result (keystream or cipher block)
ovalid  out  1  output beat valid
odata  out  N_PIPES*128  output data
okeep  out  N_PIPES*16  output keep
olast  out  1  output last
iready  in  1  downstream ready
ofeedbackiv  out  128  CBC chaining IV to the control stage
ofeedbackvalid  out  1  one-cycle pulse qualifying ofeedbackiv
odone  out  1  one-cycle pulse on the handshake of an olast beat
oerror  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous. All FIFO pointers and counters reset to 0. Outputs at reset: ctrl_ready=1, ovalid=0, olast=0, ofeedbackvalid=0, odone=0, oerror=0. odata, okeep and ofeedbackiv reset to 0.
- Reset mid-message discards all buffered beats. No output beat follows reset until new ctrl_valid/core_valid traffic arrives.
- Side FIFO:
  - Push {ctrl_data, ctrl_keep, ctrl_last} on ctrl_valid. ctrl_valid is honoured regardless of ctrl_ready.
  - Push while the side FIFO is full sets oerror, and the beat is dropped.
- Pop and combine:
  - On core_valid, pop the side-FIFO head and combine it in a registered stage (result valid the next cycle).
  - MODE=1: data = core_data ^ side_data.
  - MODE=0 or MODE=2: data = core_data (CBC decryption XOR is done inside the core).
  - keep and last always come from the side entry.
  - core_valid with the side FIFO empty (or popping on the same cycle as an empty push) sets oerror. Nothing is pushed downstream in that case.
- Output FIFO:
  - Push from the combine register.
  - Registered show-ahead output: ovalid=1 whenever non-empty. Pop on ovalid&iready.
  - Latency core_valid → ovalid is 2 cycles when the output FIFO is empty.
  - odata, okeep and olast hold stable while ovalid&!iready.
- Credit:
  - credits counts beats accepted (ctrl_valid) minus beats handshaken out, range 0..DEPTH.
  - ctrl_ready = (credits < DEPTH), registered.
  - Simultaneous accept and handshake leaves credits unchanged.
  - Credits guarantee that core_valid never finds the output FIFO full, so no overflow handling is needed there.
- CBC feedback (MODE=2 && OPERATION=0 only):
  - In the cycle after core_valid: ofeedbackvalid=1, ofeedbackiv = core_data[N_PIPES*128-1 -: 128].
  - In every other mode, ofeedbackvalid is always 0.
- odone pulses in the cycle after ovalid&iready&olast.
- oerror is sticky; only resetn clears it.

Test Plan:
- ECB, DEPTH=16: 3 ctrl beats, then core_valid with core_data=A,B,C after 10 cycles, iready=1 → odata A,B,C with ovalid 2 cycles after each core_valid; olast on the 3rd beat; odone one cycle later.
- CTR: ctrl_data=0x00…FF in all lanes, core_data=0xFF…00 → odata all-ones in every lane; okeep=all ones propagated.
- CBC encryption, N_PIPES=4: core_data top lane=0x0123…CDEF → ofeedbackvalid single pulse one cycle after core_valid, ofeedbackiv=0x0123…CDEF. In MODE 0/1 ofeedbackvalid stays 0.
- Back-pressure: iready=0, 16 beats accepted → ctrl_ready=0 after the 16th. One handshake → ctrl_ready=1 again. Outputs held stable while stalled; no data loss or reordering.
- Errors: core_valid with the side FIFO empty → oerror=1 and no ovalid; reset asserted mid-stream → all outputs return to reset values immediately (asynchronously), oerror=0, ctrl_ready=1.
